// File: rtl/multi_c_checker.sv
// multi_c_checker: self-test engine for the 4-input gate block multi_compuerta.
// Sweeps all 16 {A,B,C,D} vectors (A = MSB) and holds each one for SETTLE_CYCLES
// extra cycles. On the last cycle of each vector it samples dut_f and compares it
// with TRUTH_TABLE. It reports the mismatch count, the first failing index and pass.
// Optional feature: define MULTI_C_CHK_FAIL_MASK_EN to add the fail_mask[15:0] output.
module multi_c_checker #(
   parameter logic [15:0] TRUTH_TABLE   = 16'h8000,
   parameter int unsigned SETTLE_CYCLES = 2,
   parameter int unsigned ERR_W         = 5
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             dut_f,
   output logic             a,
   output logic             b,
   output logic             c,
   output logic             d,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic [ERR_W-1:0] err_count,
   output logic             first_err_valid,
   output logic [3:0]       first_err_idx
`ifdef MULTI_C_CHK_FAIL_MASK_EN
   ,
   output logic [15:0]      fail_mask
`endif
);

   localparam int unsigned CNT_W = 8;
   localparam logic [ERR_W-1:0] ERR_MAX = {ERR_W{1'b1}};
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE_CYCLES);

   typedef enum logic [1:0] {IDLE, SETTLE, DONE} state_t;

   state_t           state, state_n;
   logic [3:0]       idx, idx_n;
   logic [CNT_W-1:0] cnt, cnt_n;
   logic             busy_n, done_n;
   logic [ERR_W-1:0] err_n;
   logic             fev_n;
   logic [3:0]       fei_n;
   logic             mismatch;
`ifdef MULTI_C_CHK_FAIL_MASK_EN
   logic [15:0]      mask_n;
`endif

   // Stimulus outputs are the bits of the registered vector index.
   assign {a, b, c, d} = idx;

   // pass is derived directly from done and the error count.
   assign pass = done && (err_count == '0);

   // State and datapath registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state           <= IDLE;
         idx             <= '0;
         cnt             <= '0;
         busy            <= 1'b0;
         done            <= 1'b0;
         err_count       <= '0;
         first_err_valid <= 1'b0;
         first_err_idx   <= '0;
`ifdef MULTI_C_CHK_FAIL_MASK_EN
         fail_mask       <= '0;
`endif
      end else begin
         state           <= state_n;
         idx             <= idx_n;
         cnt             <= cnt_n;
         busy            <= busy_n;
         done            <= done_n;
         err_count       <= err_n;
         first_err_valid <= fev_n;
         first_err_idx   <= fei_n;
`ifdef MULTI_C_CHK_FAIL_MASK_EN
         fail_mask       <= mask_n;
`endif
      end
   end

   // Next-state and next-value logic for the sweep.
   always_comb begin
      state_n  = state;
      idx_n    = idx;
      cnt_n    = cnt;
      busy_n   = busy;
      done_n   = done;
      err_n    = err_count;
      fev_n    = first_err_valid;
      fei_n    = first_err_idx;
      mismatch = 1'b0;
`ifdef MULTI_C_CHK_FAIL_MASK_EN
      mask_n   = fail_mask;
`endif
      case (state)
         IDLE, DONE: begin
            if (start) begin
               state_n = SETTLE;
               idx_n   = '0;
               cnt_n   = CNT_LOAD;
               err_n   = '0;
               fev_n   = 1'b0;
               fei_n   = '0;
               busy_n  = 1'b1;
               done_n  = 1'b0;
`ifdef MULTI_C_CHK_FAIL_MASK_EN
               mask_n  = '0;
`endif
            end
         end
         SETTLE: begin
            if (cnt != '0) begin
               cnt_n = cnt - CNT_W'(1);
            end else begin
               mismatch = (dut_f != TRUTH_TABLE[idx]);
               if (mismatch) begin
                  if (err_count != ERR_MAX) err_n = err_count + ERR_W'(1);
                  if (!first_err_valid) begin
                     fev_n = 1'b1;
                     fei_n = idx;
                  end
`ifdef MULTI_C_CHK_FAIL_MASK_EN
                  mask_n[idx] = 1'b1;
`endif
               end
               if (idx == 4'd15) begin
                  state_n = DONE;
                  busy_n  = 1'b0;
                  done_n  = 1'b1;
               end else begin
                  idx_n = idx + 4'd1;
                  cnt_n = CNT_LOAD;
               end
            end
         end
         default: state_n = IDLE;
      endcase
   end

endmodule

// File: tb/tb_multi_c_checker.sv
// Bench for multi_c_checker: a behavioural DUT model feeds dut_f, and per-sweep expected
// results are queued at start and popped when done rises.
module tb_multi_c_checker;

   localparam int unsigned S = 2;
   localparam logic [15:0] TT = 16'h8000;

   typedef struct packed {
      logic [4:0]  err;
      logic        fev;
      logic [3:0]  fei;
      logic        pass;
      logic [15:0] mask;
   } exp_t;

   logic clk = 1'b0;
   logic rst, start, start2;
   logic dut_f, a, b, c, d, busy, done, pass, fev;
   logic [4:0] err_count;
   logic [3:0] fei;
   logic [15:0] fail_mask;
   logic dut2_f, a2, b2, c2, d2, busy2, done2, pass2, fev2;
   logic [2:0] err2;
   logic [3:0] fei2;
   logic [15:0] fail_mask2;
   int mode;
   int tests = 0;
   int fails = 0;
   exp_t exp_q[$];

   always #5 clk = ~clk;

   // Reference gate behaviour per mode: 0 AND4, 1 stuck 0, 2 stuck 1, 3 NAND4.
   function automatic logic f_of(input int m, input int i);
      case (m)
         0: return (i == 15);
         1: return 1'b0;
         2: return 1'b1;
         default: return (i != 15);
      endcase
   endfunction

   always_comb dut_f = f_of(mode, int'({a, b, c, d}));
   always_comb dut2_f = f_of(3, int'({a2, b2, c2, d2}));

   multi_c_checker u_dut (
      .clk(clk), .rst(rst), .start(start), .dut_f(dut_f),
      .a(a), .b(b), .c(c), .d(d), .busy(busy), .done(done), .pass(pass),
      .err_count(err_count), .first_err_valid(fev), .first_err_idx(fei)
`ifdef MULTI_C_CHK_FAIL_MASK_EN
      , .fail_mask(fail_mask)
`endif
   );

   multi_c_checker #(.TRUTH_TABLE(16'h8000), .SETTLE_CYCLES(0), .ERR_W(3)) u_dut2 (
      .clk(clk), .rst(rst), .start(start2), .dut_f(dut2_f),
      .a(a2), .b(b2), .c(c2), .d(d2), .busy(busy2), .done(done2), .pass(pass2),
      .err_count(err2), .first_err_valid(fev2), .first_err_idx(fei2)
`ifdef MULTI_C_CHK_FAIL_MASK_EN
      , .fail_mask(fail_mask2)
`endif
   );

`ifndef MULTI_C_CHK_FAIL_MASK_EN
   assign fail_mask  = '0;
   assign fail_mask2 = '0;
`endif

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Expected sweep result from the reference model and the truth table.
   function automatic exp_t model(input int m, input int err_max);
      exp_t e;
      int n;
      e = '0;
      n = 0;
      for (int i = 0; i < 16; i++) begin
         if (f_of(m, i) != TT[i]) begin
            if (n < err_max) n++;
            if (!e.fev) begin
               e.fev = 1'b1;
               e.fei = 4'(i);
            end
            e.mask[i] = 1'b1;
         end
      end
      e.err  = 5'(n);
      e.pass = (n == 0);
      return e;
   endfunction

   // Run one full sweep on u_dut, checking vector timing every cycle and results at done.
   task automatic run_sweep(input string name, input int m, input bit pulse_mid);
      exp_t e;
      mode = m;
      exp_q.push_back(model(m, 31));
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int k = 0; k < 16 * (S + 1); k++) begin
         tests++;
         if ({a, b, c, d} !== 4'(k / (S + 1)) || busy !== 1'b1 || done !== 1'b0 || pass !== 1'b0) begin
            fails++;
            $display("FAIL %s_cycle%0d: abcd=%h busy=%b done=%b pass=%b, want abcd=%h busy=1 done=0 pass=0",
                     name, k, {a, b, c, d}, busy, done, pass, 4'(k / (S + 1)));
         end
         if (pulse_mid && k == 14) start = 1'b1;
         tick();
         start = 1'b0;
      end
      tests++;
      if (done !== 1'b1 || busy !== 1'b0 || {a, b, c, d} !== 4'hF) begin
         fails++;
         $display("FAIL %s_done: done=%b busy=%b abcd=%h, want done=1 busy=0 abcd=f", name, done, busy, {a, b, c, d});
      end
      tests++;
      if (exp_q.size() == 0) begin
         fails++;
         $display("FAIL %s_queue: scoreboard empty, want one entry", name);
      end else begin
         e = exp_q.pop_front();
         if (err_count !== e.err || fev !== e.fev || fei !== e.fei || pass !== e.pass) begin
            fails++;
            $display("FAIL %s_result: err=%0d fev=%b fei=%0d pass=%b, want err=%0d fev=%b fei=%0d pass=%b",
                     name, err_count, fev, fei, pass, e.err, e.fev, e.fei, e.pass);
         end
`ifdef MULTI_C_CHK_FAIL_MASK_EN
         tests++;
         if (fail_mask !== e.mask) begin
            fails++;
            $display("FAIL %s_mask: fail_mask=%h, want %h", name, fail_mask, e.mask);
         end
`endif
      end
   endtask

   task automatic check_reset_vals(input string name);
      tests++;
      if ({a, b, c, d} !== 4'h0 || busy !== 1'b0 || done !== 1'b0 || pass !== 1'b0 ||
          err_count !== 5'd0 || fev !== 1'b0 || fei !== 4'd0 || fail_mask !== 16'h0) begin
         fails++;
         $display("FAIL %s: abcd=%h busy=%b done=%b pass=%b err=%0d fev=%b fei=%0d mask=%h, want all zero",
                  name, {a, b, c, d}, busy, done, pass, err_count, fev, fei, fail_mask);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      start = 1'b1;
      tick();
      tick();
      check_reset_vals("reset_with_start");
      start = 1'b0;
      rst = 1'b0;
      tick();
      check_reset_vals("reset_idle");
   endtask

   task automatic test_and4();
      run_sweep("and4", 0, 1'b0);
   endtask

   task automatic test_stuck0();
      run_sweep("stuck0", 1, 1'b0);
   endtask

   task automatic test_stuck1();
      run_sweep("stuck1", 2, 1'b0);
   endtask

   task automatic test_saturation();
      exp_t e;
      e = model(3, 7);
      start2 = 1'b1;
      tick();
      start2 = 1'b0;
      for (int k = 0; k < 16; k++) begin
         tests++;
         if ({a2, b2, c2, d2} !== 4'(k) || done2 !== 1'b0 || busy2 !== 1'b1) begin
            fails++;
            $display("FAIL sat_cycle%0d: abcd=%h done=%b busy=%b, want abcd=%h done=0 busy=1",
                     k, {a2, b2, c2, d2}, done2, busy2, 4'(k));
         end
         tick();
      end
      tests++;
      if (done2 !== 1'b1 || 5'(err2) !== e.err || fev2 !== e.fev || fei2 !== e.fei || pass2 !== 1'b0) begin
         fails++;
         $display("FAIL sat_result: done=%b err=%0d fev=%b fei=%0d pass=%b, want done=1 err=%0d fev=%b fei=%0d pass=0",
                  done2, err2, fev2, fei2, pass2, e.err, e.fev, e.fei);
      end
   endtask

   task automatic test_back_to_back();
      run_sweep("mid_start", 0, 1'b1);
      run_sweep("restart", 2, 1'b0);
   endtask

   task automatic test_abort();
      mode = 2;
      start = 1'b1;
      tick();
      start = 1'b0;
      repeat (24) tick();
      tests++;
      if (err_count === 5'd0 || busy !== 1'b1) begin
         fails++;
         $display("FAIL abort_pre: err=%0d busy=%b, want err>0 busy=1", err_count, busy);
      end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check_reset_vals("abort_reset");
      tick();
      check_reset_vals("abort_no_done");
      run_sweep("after_abort", 0, 1'b0);
   endtask

   initial begin
      rst = 1'b1;
      start = 1'b0;
      start2 = 1'b0;
      mode = 0;
      test_reset();
      test_and4();
      test_stuck0();
      test_stuck1();
      test_saturation();
      test_back_to_back();
      test_abort();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
